// File: rtl/updown_counter.sv
// Up/down modulo counter with optional saturation, a one-cycle wrap pulse and a sticky
// overflow flag. Priority per edge is clear > load > enable > hold.
module updown_counter #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned MODULUS  = 2 ** NUM_BITS,
    parameter int unsigned SATURATE = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                up,
    input  logic                clear,
    input  logic                load,
    input  logic [NUM_BITS-1:0] load_value,
    output logic [NUM_BITS-1:0] count,
    output logic                at_max,
    output logic                at_min,
    output logic                wrap,
    output logic                overflow
);

    localparam logic [NUM_BITS-1:0] MaxVal = NUM_BITS'(MODULUS - 1);
    localparam logic [NUM_BITS-1:0] One    = NUM_BITS'(1);

    logic [NUM_BITS-1:0] count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (load) begin
            // Out-of-range load values clamp to the top of the range.
            count_d = (load_value > MaxVal) ? MaxVal : load_value;
        end else if (enable) begin
            if (up) begin
                if (count_q == MaxVal) begin
                    wrap_d     = 1'b1;
                    overflow_d = 1'b1;
                    count_d    = (SATURATE != 0) ? count_q : '0;
                end else begin
                    count_d = count_q + One;
                end
            end else begin
                if (count_q == '0) begin
                    wrap_d     = 1'b1;
                    overflow_d = 1'b1;
                    count_d    = (SATURATE != 0) ? count_q : MaxVal;
                end else begin
                    count_d = count_q - One;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign overflow = overflow_q;
    assign at_max   = (count_q == MaxVal);
    assign at_min   = (count_q == '0);

endmodule

// File: doc/updown_counter.md
UPDOWN_COUNTER -- requirements
Module: updown_counter

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, width of count.
REQ-002 SHALL have parameter MODULUS, default 2**NUM_BITS, count range 0..MODULUS-1; legal range 2..2**NUM_BITS.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  advance count by one step when high.
REQ-007 SHALL have port up  input  1  step direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port clear  input  1  synchronous clear of count and status.
REQ-009 SHALL have port load  input  1  synchronous load of load_value.
REQ-010 SHALL have port load_value  input  NUM_BITS  value for load.
REQ-011 SHALL have port count  output  NUM_BITS  current count, registered.
REQ-012 SHALL have port at_max  output  1  combinational; high when count == MODULUS-1.
REQ-013 SHALL have port at_min  output  1  combinational; high when count == 0.
REQ-014 SHALL have port wrap  output  1  registered one-cycle pulse; a range end was crossed (SATURATE=0) or a step was blocked (SATURATE=1) on the previous edge.
REQ-015 SHALL have port overflow  output  1  registered sticky flag; set on any wrap or blocked step.

Function
REQ-016 Per-edge priority SHALL be clear > load > enable > hold.
REQ-017 clear SHALL set count=0, wrap=0, overflow=0 on the next edge.
REQ-018 load SHALL set count=load_value on the next edge; load_value >= MODULUS SHALL load MODULUS-1; load SHALL set wrap=0 and leave overflow unchanged.
REQ-019 With enable=1, up=1, count < MODULUS-1: count SHALL become count+1 on the next edge, wrap=0.
REQ-020 With enable=1, up=0, count > 0: count SHALL become count-1 on the next edge, wrap=0.
REQ-021 With enable=1, up=1, count == MODULUS-1: SATURATE=0 SHALL give count=0; SATURATE=1 SHALL hold count; both SHALL set wrap=1 for one cycle and set overflow.
REQ-022 With enable=1, up=0, count == 0: SATURATE=0 SHALL give count=MODULUS-1; SATURATE=1 SHALL hold count; both SHALL set wrap=1 for one cycle and set overflow.
REQ-023 With enable=0 and no clear or load: count and overflow SHALL hold and wrap SHALL be 0.
REQ-024 Consecutive wrapping steps SHALL hold wrap high on each such cycle.
REQ-025 Changing up while enable is high SHALL take effect on the same edge, with no bubble.
REQ-026 With MODULUS == 2**NUM_BITS, arithmetic SHALL use natural NUM_BITS rollover and never an out-of-range intermediate value.
REQ-027 count SHALL never take a value >= MODULUS.

Reset
REQ-028 reset low SHALL immediately force count=0, wrap=0, overflow=0, independent of clk.
REQ-029 reset asserted mid-count SHALL discard any pending step, load or clear.
REQ-030 After reset deasserts, the first state update SHALL occur on the next rising edge, using the inputs sampled there.
REQ-031 After reset, at_min=1 and at_max=0 SHALL hold.

Verification
REQ-032 NUM_BITS=8, MODULUS=256, SATURATE=0; reset low 10 ns, enable=1, up=1 for 300 edges -> count runs 0..255 then 0..43; wrap pulses once, on the edge after 255->0; overflow=1 thereafter.
REQ-033 MODULUS=10, SATURATE=0; load 0, then up=0, enable=1 for 1 edge -> count=9, wrap=1 for one cycle, at_max=1.
REQ-034 MODULUS=10, SATURATE=1; load 8, then up=1, enable=1 for 4 edges -> count sequence 9,9,9,9; wrap=1 on edges 2-4; overflow=1.
REQ-035 MODULUS=10; load_value=200 with load=1 -> count=9; load and clear together -> count=0, overflow=0; load and enable together -> load wins.
REQ-036 Count to 37 with enable toggling 5 edges on, 5 off; assert reset low between edges -> count=0 asynchronously; count holds 0 until the first edge after release, then resumes from 1.
